// File: rtl/ntt_commutator.sv
`default_nettype none
// ============================================================================
// Module   : ntt_commutator
// Purpose  : Delay commutator placed ahead of an NTT/INTT butterfly stage.
//            Reorders a two-lane coefficient stream so that each output pair
//            holds samples D = 2**DELAY_LOG accepted beats apart. The design
//            uses two D-deep read-before-write delay lines and a two-way
//            switch driven by the beat counter.
// Options  : `define NTT_COMMUTATOR_FLUSH_EN adds flush/busy ports. A flush
//            pulse triggers a D-cycle auto-drain of zero beats.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_commutator #(
    parameter int WIDTH     = 12,
    parameter int DELAY_LOG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
`ifdef NTT_COMMUTATOR_FLUSH_EN
    input  logic             flush,
    output logic             busy,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);

    localparam int c_DEPTH = 1 << DELAY_LOG;
    localparam int c_PW    = (DELAY_LOG > 0) ? DELAY_LOG : 1;

    logic [DELAY_LOG:0] r_cnt;
    logic               r_primed;
    logic [c_PW-1:0]    w_ptr;
    logic               w_sel;
    logic               w_accept;
    logic               w_drain_last;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH-1:0]   w_qd;
    logic [WIDTH-1:0]   w_top;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   r_ram_a [c_DEPTH];
    logic [WIDTH-1:0]   r_ram_q [c_DEPTH];
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_a;
    logic [WIDTH-1:0]   r_out_b;

    // When D = 1, each delay line holds a single entry, so the pointer is always zero.
    generate
        if (DELAY_LOG == 0) begin : g_ptr_single
            assign w_ptr = '0;
        end else begin : g_ptr_multi
            assign w_ptr = r_cnt[DELAY_LOG-1:0];
        end
    endgenerate

    assign w_sel = r_cnt[DELAY_LOG];

`ifdef NTT_COMMUTATOR_FLUSH_EN
    logic            r_busy;
    logic [c_PW-1:0] r_drain;

    // During a drain, the block accepts zero beats internally and ignores in_valid.
    assign busy         = r_busy;
    assign w_accept     = r_busy | in_valid;
    assign w_a          = r_busy ? '0 : in_a;
    assign w_b          = r_busy ? '0 : in_b;
    assign w_drain_last = r_busy && (r_drain == c_PW'(c_DEPTH - 1));

    // The drain sequencer starts only from idle and runs for exactly D cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_drain <= '0;
        end else if (r_busy) begin
            if (w_drain_last) begin
                r_busy  <= 1'b0;
                r_drain <= '0;
            end else begin
                r_drain <= r_drain + 1'b1;
            end
        end else if (flush) begin
            r_busy  <= 1'b1;
            r_drain <= '0;
        end
    end
`else
    assign w_accept     = in_valid;
    assign w_a          = in_a;
    assign w_b          = in_b;
    assign w_drain_last = 1'b0;
`endif

    // Both delay lines are read before they are written, so the read value is the sample from D beats earlier.
    assign w_p   = r_ram_a[w_ptr];
    assign w_qd  = r_ram_q[w_ptr];
    assign w_top = w_sel ? w_b : w_p;
    assign w_q   = w_sel ? w_p : w_b;

    // Delay-line writes. Contents are not reset; stale data is masked by out_valid until the pipeline is primed.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            r_ram_a[w_ptr] <= w_a;
            r_ram_q[w_ptr] <= w_q;
        end
    end

    // The beat counter wraps at 2D. The primed flag is set once the first D beats have been accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_primed <= 1'b0;
        end else if (w_accept) begin
            if (w_drain_last) begin
                r_cnt    <= '0;
                r_primed <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == (DELAY_LOG + 1)'(c_DEPTH - 1)) begin
                    r_primed <= 1'b1;
                end
            end
        end
    end

    // Output registers. The data registers hold their values on idle cycles, and out_valid is raised only for primed accepted beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
        end else begin
            r_out_valid <= w_accept & r_primed;
            if (w_accept) begin
                r_out_a <= w_qd;
                r_out_b <= w_top;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;

endmodule
`default_nettype wire

// File: tb/tb_ntt_commutator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ntt_commutator
// Purpose  : Directed self-checking bench for ntt_commutator, run with
//            D = 2, D = 1 and D = 8 instances sharing the same input stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_commutator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_a;
    logic [11:0] in_b;

    logic        ov2, ov1, ov8;
    logic [11:0] oa2, ob2, oa1, ob1, oa8, ob8;

    int vectors;
    int miscompares;

    logic [11:0] sa [72];
    logic [11:0] sb [72];

    ntt_commutator #(.WIDTH(12), .DELAY_LOG(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .out_valid(ov2), .out_a(oa2), .out_b(ob2)
    );

    ntt_commutator #(.WIDTH(12), .DELAY_LOG(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .out_valid(ov1), .out_a(oa1), .out_b(ob1)
    );

    ntt_commutator #(.WIDTH(12), .DELAY_LOG(3)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
        .out_valid(ov8), .out_a(oa8), .out_b(ob8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input, then sample 1 ns after the active edge.
    task automatic step(input logic v, input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
    endtask

    // Assert reset for one edge. Inputs stay live to exercise reset priority.
    task automatic do_reset(input logic v);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = v;
        in_a     = 12'd99;
        in_b     = 12'd99;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check one output beat. Data lanes are compared only when the beat is expected to be valid.
    task automatic chk(input string tag, input logic ov, input logic [11:0] oa, input logic [11:0] ob,
                       input logic ev, input logic [11:0] ea, input logic [11:0] eb);
        cmp({tag, ".valid"}, {11'd0, ov}, {11'd0, ev});
        if (ev) begin
            cmp({tag, ".a"}, oa, ea);
            cmp({tag, ".b"}, ob, eb);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;

        // Reset state.
        do_reset(1'b0);
        do_reset(1'b0);
        cmp("rst.valid2", {11'd0, ov2}, 12'd0);
        cmp("rst.a2", oa2, 12'd0);
        cmp("rst.b2", ob2, 12'd0);
        cmp("rst.valid1", {11'd0, ov1}, 12'd0);

        // D=1: beats (5,6), (7,8), (0,0).
        step(1, 5, 6);  chk("d1.b0", ov1, oa1, ob1, 0, 0, 0);
        step(1, 7, 8);  chk("d1.b1", ov1, oa1, ob1, 1, 6, 8);
        step(1, 0, 0);  chk("d1.b2", ov1, oa1, ob1, 1, 5, 7);
        step(0, 0, 0);  chk("d1.idle", ov1, oa1, ob1, 0, 0, 0);

        // D=2: contiguous beats followed by two filler beats.
        do_reset(1'b0);
        step(1, 1, 11); chk("t1.b0", ov2, oa2, ob2, 0, 0, 0);
        step(1, 2, 12); chk("t1.b1", ov2, oa2, ob2, 0, 0, 0);
        step(1, 3, 13); chk("t1.b2", ov2, oa2, ob2, 1, 11, 13);
        step(1, 4, 14); chk("t1.b3", ov2, oa2, ob2, 1, 12, 14);
        step(1, 0, 0);  chk("t1.f0", ov2, oa2, ob2, 1, 1, 3);
        step(1, 0, 0);  chk("t1.f1", ov2, oa2, ob2, 1, 2, 4);

        // D=2: the same stream with an idle cycle after every beat.
        do_reset(1'b0);
        step(1, 1, 11); chk("t2.b0", ov2, oa2, ob2, 0, 0, 0);
        step(0, 7, 7);  chk("t2.i0", ov2, oa2, ob2, 0, 0, 0);
        step(1, 2, 12); chk("t2.b1", ov2, oa2, ob2, 0, 0, 0);
        step(0, 7, 7);  chk("t2.i1", ov2, oa2, ob2, 0, 0, 0);
        step(1, 3, 13); chk("t2.b2", ov2, oa2, ob2, 1, 11, 13);
        step(0, 7, 7);  chk("t2.i2", ov2, oa2, ob2, 0, 0, 0);
        cmp("t2.hold_a", oa2, 12'd11);
        cmp("t2.hold_b", ob2, 12'd13);
        step(1, 4, 14); chk("t2.b3", ov2, oa2, ob2, 1, 12, 14);
        step(0, 7, 7);  chk("t2.i3", ov2, oa2, ob2, 0, 0, 0);
        step(1, 0, 0);  chk("t2.f0", ov2, oa2, ob2, 1, 1, 3);
        step(0, 7, 7);  chk("t2.i4", ov2, oa2, ob2, 0, 0, 0);
        step(1, 0, 0);  chk("t2.f1", ov2, oa2, ob2, 1, 2, 4);

        // D=2: reset mid-stream while in_valid is high. Data from before the reset must not reappear.
        do_reset(1'b0);
        step(1, 1, 11); chk("t3.pre0", ov2, oa2, ob2, 0, 0, 0);
        step(1, 2, 12); chk("t3.pre1", ov2, oa2, ob2, 0, 0, 0);
        do_reset(1'b1);
        cmp("t3.rst_valid", {11'd0, ov2}, 12'd0);
        cmp("t3.rst_a", oa2, 12'd0);
        step(1, 9, 19);  chk("t3.b0", ov2, oa2, ob2, 0, 0, 0);
        step(1, 10, 20); chk("t3.b1", ov2, oa2, ob2, 0, 0, 0);
        step(1, 11, 21); chk("t3.b2", ov2, oa2, ob2, 1, 19, 21);
        step(1, 12, 22); chk("t3.b3", ov2, oa2, ob2, 1, 20, 22);
        step(1, 0, 0);   chk("t3.f0", ov2, oa2, ob2, 1, 9, 11);
        step(1, 0, 0);   chk("t3.f1", ov2, oa2, ob2, 1, 10, 12);

        // D=8: 64 random beats plus 8 fillers, checked against the output pairing rule.
        do_reset(1'b0);
        for (int n = 0; n < 72; n++) begin
            int j;
            logic        ev;
            logic [11:0] ea, eb;
            sa[n] = (n < 64) ? 12'($urandom_range(0, 3328)) : 12'd0;
            sb[n] = (n < 64) ? 12'($urandom_range(0, 3328)) : 12'd0;
            step(1, sa[n], sb[n]);
            j  = n % 16;
            ev = 1'b0;
            ea = '0;
            eb = '0;
            if (j >= 8) begin
                ev = 1'b1;
                ea = sb[n-8];
                eb = sb[n];
            end else if (n >= 16) begin
                ev = 1'b1;
                ea = sa[n-16];
                eb = sa[n-8];
            end
            chk($sformatf("d8.n%0d", n), ov8, oa8, ob8, ev, ea, eb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_commutator.md
Name: ntt_commutator

Overview:
- Delay-commutator that sits directly upstream of each NTT/INTT butterfly stage.
- Takes a two-lane coefficient stream whose pairs are (x_i, x_{i+?}) from the previous stage and reorders it so each output pair holds samples 2^DELAY_LOG beats apart, as the next butterfly requires.
- Provides the "fifo1" (depth 2^n) reorder storage and its switch controller.
- Storage is two D-deep single-address RAM delay lines (read-before-write at the same address), matching the team's dp_ram style.

Parameters:
- WIDTH, 12, coefficient width in bits (Kyber q=3329).
- DELAY_LOG, 1, log2 of delay depth D = 2^DELAY_LOG. Legal range 0..7.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat accepted this cycle.
- in_a  input  WIDTH  upper lane input.
- in_b  input  WIDTH  lower lane input.
- out_valid  output  1  registered output beat valid.
- out_a  output  WIDTH  registered upper lane output.
- out_b  output  WIDTH  registered lower lane output.

Interface requirement (already decided): one clock; reset is synchronous and active-high, ports named clk and rst.

Behaviour:
- Pipeline advances only on cycles with in_valid=1. No backpressure; idle cycles freeze all state (counter, RAM pointers, primed flag); out_valid=0 on those cycles.
- Beat counter c, DELAY_LOG+1 bits, increments per accepted beat and wraps 2D-1 -> 0. Write/read pointer = c[DELAY_LOG-1:0], shared by both delay lines. sel = c[DELAY_LOG].
- Delay line A: p = in_a delayed D accepted beats.
- Switch:
  - sel=0: top = p, q = in_b.
  - sel=1: top = in_b, q = p.
- Delay line Q: qd = q delayed D accepted beats.
- On an accepted beat, the registered outputs update on the next clock edge:
  - out_a <= qd
  - out_b <= top
  - out_valid <= primed
- Resulting order, for block index j = c at acceptance:
  - j in [D,2D): output (b_{j-D}, b_j) of the current block.
  - j in [0,D): output (a_j, a_{j+D}) of the previous block.
- primed: cleared by reset; set after D accepted beats since reset and stays set. The first D accepted beats after reset produce out_valid=0.
- Latency: 1 clock from accepted beat to out_* update. Data latency is D accepted beats for the b-half and 2D accepted beats for the a-half.
- Draining: the final block's a-half is emitted only when D further beats are accepted. Upstream supplies filler beats, or uses the optional flush.
- DELAY_LOG=0 (D=1): delay lines degenerate to single registers. Pointer width is 0; sel = c[0].
- Reset values: out_valid=0, out_a=0, out_b=0, c=0, primed=0.
  - RAM contents are not reset; values read before priming are don't-care and masked by out_valid.
  - Reset mid-stream discards all in-flight data; the next accepted beat is j=0 of a fresh, unprimed stream.
- Reset has priority over in_valid in the same cycle.

Optional Feature:
- Macro NTT_COMMUTATOR_FLUSH_EN.
- Defined: adds ports flush (input, 1) and busy (output, 1, reset 0).
  - A flush pulse while busy=0 starts an auto-drain: for the next D cycles the block internally accepts beats with a=b=0 regardless of in_valid. External in_valid during busy=1 is ignored and data dropped.
  - busy=1 exactly those D cycles.
  - At drain end, c, primed and outputs behave as if reset, so out_valid=0 until re-primed.
  - flush during busy is ignored. flush and in_valid in the same idle cycle: the beat is accepted first, the drain starts next cycle.
- Undefined: no flush/busy ports; draining only via upstream filler beats.

Test Plan:
- D=2, contiguous beats a=1,2,3,4 with b=11,12,13,14, then a=b=0 for 2 beats -> out_valid low for beats 0-1; outputs in order (11,13), (12,14), (1,3), (2,4), one clock after each accepted beat.
- Same stimulus with in_valid gaps (valid every other cycle) -> identical output sequence; out_valid=0 on idle cycles; state frozen.
- D=1, beats (5,6), (7,8), (0,0) -> outputs (6,8) then (5,7); first beat out_valid=0.
- Assert rst after beat 2 of the first test, then restart with a=9,10,11,12, b=19,20,21,22 -> no pre-reset data appears; outputs (19,21), (20,22), (9,11), (10,12) after priming.
- DELAY_LOG=3, 64 random beats plus 8 filler beats -> scoreboard matches the pairing rule for every valid output.
- NTT_COMMUTATOR_FLUSH_EN, D=2: feed 4 beats of test 1, pulse flush, hold in_valid=1 with garbage during busy -> busy high 2 cycles; outputs (1,3), (2,4) emitted; garbage ignored; out_valid=0 afterwards until 2 new beats.
